mdu_iterative: RTL and testbench



---
 rtl/mdu_iterative_if.sv | 35 +++
 rtl/mdu_iterative.sv | 161 ++++++++++++++++
 tb/tb_mdu_iterative.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mdu_iterative_if.sv
//==============================================================================
// Module      : mdu_iterative_if
// Description : EXE-stage bundle between the pipeline and the iterative
//               multiply/divide unit (operands, op code, kill, stall, result).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mdu_iterative_if #(
    parameter int XLEN = 32
);
    logic            op_valid;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            kill;
    logic            exe_ready;
    logic [XLEN-1:0] result;
    logic            result_valid;
    logic            busy;

    // Pipeline side: presents the instruction, consumes stall and result
    modport master (
        output op_valid, op, rs1_data, rs2_data, kill,
        input  exe_ready, result, result_valid, busy
    );

    // Unit side
    modport slave (
        input  op_valid, op, rs1_data, rs2_data, kill,
        output exe_ready, result, result_valid, busy
    );
endinterface

`default_nettype wire

// File: rtl/mdu_iterative.sv
//==============================================================================
// Module      : mdu_iterative
// Description : Multi-cycle RV32M multiply/divide unit. Radix-2 shift-add
//               multiply and restoring divide on operand magnitudes, one bit
//               per cycle, with sign correction applied on the last step.
//               Divide-by-zero and signed overflow resolve in one cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mdu_iterative #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mdu_iterative_if.slave    bus
);

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand (mul) or divisor (div)
    logic [2*XLEN-1:0] acc_q, acc_d;       // {hi, multiplier} or {remainder, quotient}
    logic [XLEN-1:0]   result_q, result_d;
    logic              result_valid_q, result_valid_d;

    // Launch decode: signedness, magnitudes, result sign and special cases
    logic            is_div, a_neg, b_neg, neg_launch, div_zero, div_ovf, special;
    logic [XLEN-1:0] abs_a, abs_b, special_res;
    always_comb begin
        is_div     = bus.op[2];
        a_neg      = bus.rs1_data[XLEN-1] & (is_div ? ~bus.op[0] : (bus.op != 3'd3));
        b_neg      = bus.rs2_data[XLEN-1] & (is_div ? ~bus.op[0] : ~bus.op[1]);
        abs_a      = a_neg ? -bus.rs1_data : bus.rs1_data;
        abs_b      = b_neg ? -bus.rs2_data : bus.rs2_data;
        // Remainder follows the dividend; everything else follows the sign product
        neg_launch = (is_div && bus.op[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero   = is_div && (bus.rs2_data == {XLEN{1'b0}});
        div_ovf    = is_div && !bus.op[0] && (bus.rs1_data == MIN_NEG) &&
                     (bus.rs2_data == {XLEN{1'b1}});
        special    = div_zero || div_ovf;
        if (div_zero) begin
            special_res = bus.op[1] ? bus.rs1_data : {XLEN{1'b1}};
        end else begin
            special_res = bus.op[1] ? {XLEN{1'b0}} : MIN_NEG;
        end
    end

    // One datapath iteration plus sign correction of the would-be final value
    logic [XLEN:0]     mul_sum, div_trial, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, step, prod;
    logic [XLEN-1:0]   div_raw, final_res;
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_trial = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_trial - {1'b0, opnd_q};
        if (!div_diff[XLEN]) begin
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
        step    = op_q[2] ? div_next : mul_next;
        prod    = neg_q ? -step : step;
        div_raw = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
        if (op_q[2]) begin
            final_res = neg_q ? -div_raw : div_raw;
        end else begin
            final_res = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic: launch, iterate, report for one cycle; kill wins everywhere
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        neg_d          = neg_q;
        opnd_d         = opnd_q;
        acc_d          = acc_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        if (bus.kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        if (special) begin
                            state_d        = S_DONE;
                            result_d       = special_res;
                            result_valid_d = 1'b1;
                        end else begin
                            state_d = S_BUSY;
                            cnt_d   = {CNT_W{1'b0}};
                            op_d    = bus.op;
                            neg_d   = neg_launch;
                            opnd_d  = is_div ? abs_b : abs_a;
                            acc_d   = {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
                        end
                    end
                end
                S_BUSY: begin
                    acc_d = step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d        = S_DONE;
                        result_d       = final_res;
                        result_valid_d = 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= {CNT_W{1'b0}};
            op_q           <= 3'd0;
            neg_q          <= 1'b0;
            opnd_q         <= {XLEN{1'b0}};
            acc_q          <= {(2*XLEN){1'b0}};
            result_q       <= {XLEN{1'b0}};
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            neg_q          <= neg_d;
            opnd_q         <= opnd_d;
            acc_q          <= acc_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Stall the front end while an op is pending; op_valid is ignored in reset
    assign bus.exe_ready    = !rst_n || bus.kill || (state_q == S_DONE) ||
                              ((state_q == S_IDLE) && !bus.op_valid);
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = (state_q == S_BUSY);

endmodule

`default_nettype wire

// File: tb/tb_mdu_iterative.sv
//==============================================================================
// Module      : tb_mdu_iterative
// Description : Directed self-checking bench for mdu_iterative.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mdu_iterative;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mdu_iterative_if #(.XLEN(32)) bus ();

    mdu_iterative #(.XLEN(32), .ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present an op, count stall cycles until exe_ready, then check the result
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_stall);
        int stall;
        stall = 0;
        @(posedge clk); #1;
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.rs1_data = a;
        bus.rs2_data = b;
        @(negedge clk);
        while (bus.exe_ready !== 1'b1 && stall < 60) begin
            stall++;
            @(negedge clk);
        end
        check({tag, " stall"}, 32'(stall), 32'(exp_stall));
        check({tag, " valid"}, {31'd0, bus.result_valid}, 32'd1);
        check({tag, " result"}, bus.result, exp_res);
    endtask

    // Front end advances with a bubble; unit must be idle and quiet
    task automatic go_idle(input string tag);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        @(negedge clk);
        check({tag, " idle valid"}, {31'd0, bus.result_valid}, 32'd0);
        check({tag, " idle busy"},  {31'd0, bus.busy},         32'd0);
        check({tag, " idle ready"}, {31'd0, bus.exe_ready},    32'd1);
    endtask

    initial begin
        logic seen_valid;
        rst_n        = 1'b0;
        bus.op_valid = 1'b0;
        bus.op       = 3'd0;
        bus.rs1_data = 32'd0;
        bus.rs2_data = 32'd0;
        bus.kill     = 1'b0;
        #3;
        check("rst ready",  {31'd0, bus.exe_ready},    32'd1);
        check("rst valid",  {31'd0, bus.result_valid}, 32'd0);
        check("rst busy",   {31'd0, bus.busy},         32'd0);
        check("rst result", bus.result,                32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Iterative divide
        run_op("divu 100/7",  3'd5, 32'd100,        32'd7, 32'd14,         33);
        go_idle("divu");
        run_op("rem -7/2",    3'd6, 32'hFFFF_FFF9,  32'd2, 32'hFFFF_FFFF,  33);
        run_op("div -7/2",    3'd4, 32'hFFFF_FFF9,  32'd2, 32'hFFFF_FFFD,  33);
        run_op("div 20/-6",   3'd4, 32'd20, 32'hFFFF_FFFA, 32'hFFFF_FFFD,  33);
        run_op("rem 20/-6",   3'd6, 32'd20, 32'hFFFF_FFFA, 32'd2,          33);
        run_op("remu 100/7",  3'd7, 32'd100,        32'd7, 32'd2,          33);
        go_idle("signed div");

        // Single-cycle special cases
        run_op("divu x/0",    3'd5, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu 1234/0", 3'd7, 32'h0000_1234, 32'd0, 32'h0000_1234, 1);
        run_op("div 5/0",     3'd4, 32'd5,         32'd0, 32'hFFFF_FFFF, 1);
        run_op("div ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        go_idle("special");

        // Multiply variants
        run_op("mulh min*min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhu -1*-1",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulhsu -1*-1",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("mul 3*-5",      3'd0, 32'd3,         32'hFFFF_FFFB, 32'hFFFF_FFF1, 33);
        run_op("mul 2^16*2^16", 3'd0, 32'h0001_0000, 32'h0001_0000, 32'd0,         33);
        run_op("mulhu 2^16^2",  3'd3, 32'h0001_0000, 32'h0001_0000, 32'd1,         33);
        go_idle("mul");

        // Kill at BUSY counter 10
        @(posedge clk); #1;
        bus.op_valid = 1'b1;
        bus.op       = 3'd5;
        bus.rs1_data = 32'd100;
        bus.rs2_data = 32'd7;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(negedge clk);
        check("kill ready", {31'd0, bus.exe_ready}, 32'd1);
        check("kill busy",  {31'd0, bus.busy},      32'd1);
        seen_valid = bus.result_valid;
        @(posedge clk); #1;
        bus.kill     = 1'b0;
        bus.op_valid = 1'b0;
        @(negedge clk);
        check("kill idle", {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            seen_valid = seen_valid | bus.result_valid;
            @(negedge clk);
        end
        check("kill no result", {31'd0, seen_valid}, 32'd0);
        run_op("after kill", 3'd5, 32'd100, 32'd7, 32'd14, 33);
        go_idle("after kill");

        // Asynchronous reset at BUSY counter 20
        @(posedge clk); #1;
        bus.op_valid = 1'b1;
        bus.op       = 3'd5;
        bus.rs1_data = 32'd1000;
        bus.rs2_data = 32'd10;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst busy",   {31'd0, bus.busy},         32'd0);
        check("arst valid",  {31'd0, bus.result_valid}, 32'd0);
        check("arst result", bus.result,                32'd0);
        check("arst ready",  {31'd0, bus.exe_ready},    32'd1);
        @(negedge clk);
        bus.op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("b2b divu 1000/10", 3'd5, 32'd1000,      32'd10, 32'd100,        33);
        run_op("b2b divu max/3",   3'd5, 32'hFFFF_FFFF, 32'd3,  32'h5555_5555,  33);
        go_idle("b2b");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
